// File: rtl/mem_req_stage.sv
// mem_req_stage: memory-request pipeline stage. Holds one instruction at a
// time, issues its data-SRAM request, waits for the response, extracts and
// extends load data, and presents the result downstream.
//
// Ports:
//   clk, resetn                 clock, asynchronous active-low reset
//   in_valid/in_allowin         upstream handshake
//   in_pc, in_result            instruction PC, ALU result (memory address)
//   in_mem_op                   {ld, st, size[1:0], sext}
//   in_wdata                    store data
//   in_rf_we, in_rf_waddr       writeback control
//   cancel                      flush of the held instruction
//   out_valid/out_ready         downstream handshake
//   out_pc, out_rf_*            writeback to the next stage
//   out_ale, out_badv           misaligned-address exception and address
//   fwd_busy                    held load has not captured its data yet
//   data_sram_*                 request/response memory interface
//
// Configuration macro: MEM_ALE_CHECK_EN enables misaligned-access detection.
// Without it out_ale/out_badv are tied low and every access is issued.
module mem_req_stage #(
    parameter int RF_AW   = 5,
    parameter int DRAIN_W = 2
) (
    input  logic             clk,
    input  logic             resetn,
    input  logic             in_valid,
    output logic             in_allowin,
    input  logic [31:0]      in_pc,
    input  logic [31:0]      in_result,
    input  logic [4:0]       in_mem_op,
    input  logic [31:0]      in_wdata,
    input  logic             in_rf_we,
    input  logic [RF_AW-1:0] in_rf_waddr,
    input  logic             cancel,
    output logic             out_valid,
    input  logic             out_ready,
    output logic [31:0]      out_pc,
    output logic             out_rf_we,
    output logic [RF_AW-1:0] out_rf_waddr,
    output logic [31:0]      out_rf_wdata,
    output logic             out_ale,
    output logic [31:0]      out_badv,
    output logic             fwd_busy,
    output logic             data_sram_req,
    output logic             data_sram_wr,
    output logic [1:0]       data_sram_size,
    output logic [31:0]      data_sram_addr,
    output logic [3:0]       data_sram_wstrb,
    output logic [31:0]      data_sram_wdata,
    input  logic             data_sram_addr_ok,
    input  logic             data_sram_data_ok,
    input  logic [31:0]      data_sram_rdata
);

    typedef enum logic [1:0] {
        S_IDLE = 2'd0,
        S_REQ  = 2'd1,
        S_WAIT = 2'd2,
        S_DONE = 2'd3
    } state_t;

    localparam logic [DRAIN_W-1:0] DRAIN_MAX  = {DRAIN_W{1'b1}};
    localparam logic [DRAIN_W-1:0] DRAIN_ZERO = {DRAIN_W{1'b0}};
    localparam logic [DRAIN_W-1:0] DRAIN_ONE  = {{(DRAIN_W-1){1'b0}}, 1'b1};

    // Byte-enable pattern for a store of the given size at address offset a.
    function automatic logic [3:0] store_strb(input logic [1:0] size, input logic [1:0] a);
        logic [3:0] s;
        case (size)
            2'd0: begin
                case (a)
                    2'd0:    s = 4'b0001;
                    2'd1:    s = 4'b0010;
                    2'd2:    s = 4'b0100;
                    default: s = 4'b1000;
                endcase
            end
            2'd1:    s = a[1] ? 4'b1100 : 4'b0011;
            default: s = 4'b1111;
        endcase
        return s;
    endfunction

    // Store data replicated across every lane so any byte enable sees it.
    function automatic logic [31:0] store_data(input logic [1:0] size, input logic [31:0] d);
        logic [31:0] r;
        case (size)
            2'd0:    r = {4{d[7:0]}};
            2'd1:    r = {2{d[15:0]}};
            default: r = d;
        endcase
        return r;
    endfunction

    // Lane select plus zero/sign extension of returned load data.
    function automatic logic [31:0] load_data(input logic [1:0] size, input logic sext,
                                              input logic [1:0] a, input logic [31:0] rd);
        logic [7:0]  b;
        logic [15:0] h;
        logic [31:0] r;
        case (a)
            2'd0:    b = rd[7:0];
            2'd1:    b = rd[15:8];
            2'd2:    b = rd[23:16];
            default: b = rd[31:24];
        endcase
        h = a[1] ? rd[31:16] : rd[15:0];
        case (size)
            2'd0:    r = {{24{sext & b[7]}}, b};
            2'd1:    r = {{16{sext & h[15]}}, h};
            default: r = rd;
        endcase
        return r;
    endfunction

    state_t             state_r, state_nxt_s;
    logic [DRAIN_W-1:0] drain_cnt_r;
    logic [31:0]        pc_r, addr_r, sram_wdata_r, rf_wdata_r;
    logic               ld_r, st_r, sext_r, rf_we_r;
    logic [1:0]         size_r;
    logic [3:0]         wstrb_r;
    logic [RF_AW-1:0]   rf_waddr_r;

    logic               xfer_s, in_ale_s, drain_zero_s, own_resp_s;
    logic               drain_inc_s, drain_dec_s;
    state_t             enter_s;

`ifdef MEM_ALE_CHECK_EN
    assign in_ale_s = (in_mem_op[4] | in_mem_op[3]) &
                      (((in_mem_op[2:1] == 2'd1) & in_result[0]) |
                       ((in_mem_op[2:1] == 2'd2) & (in_result[1:0] != 2'd0)));
`else
    assign in_ale_s = 1'b0;
`endif

    assign drain_zero_s = (drain_cnt_r == DRAIN_ZERO);
    assign in_allowin   = ((state_r == S_IDLE) | ((state_r == S_DONE) & out_ready)) &
                          (drain_cnt_r != DRAIN_MAX);
    // A cancel flushes this stage, so an upstream offer in the same cycle is dropped.
    assign xfer_s       = in_valid & in_allowin & ~cancel;
    assign enter_s      = ((in_mem_op[4] | in_mem_op[3]) & ~in_ale_s) ? S_REQ : S_DONE;
    // Responses are in order: while discards are pending, data_ok belongs to an older request.
    assign own_resp_s   = (state_r == S_WAIT) & data_sram_data_ok & drain_zero_s;
    assign drain_dec_s  = data_sram_data_ok & ~drain_zero_s;
    // A cancelled request whose address was accepted still owes a response.
    assign drain_inc_s  = cancel & (((state_r == S_REQ) & data_sram_addr_ok) |
                                    ((state_r == S_WAIT) & ~own_resp_s));

    // Next-state selection for the single-entry request FSM.
    always_comb begin
        state_nxt_s = state_r;
        case (state_r)
            S_IDLE: begin
                if (xfer_s) state_nxt_s = enter_s;
                else        state_nxt_s = S_IDLE;
            end
            S_REQ: begin
                if (cancel)                 state_nxt_s = S_IDLE;
                else if (data_sram_addr_ok) state_nxt_s = S_WAIT;
                else                        state_nxt_s = S_REQ;
            end
            S_WAIT: begin
                if (cancel)          state_nxt_s = S_IDLE;
                else if (own_resp_s) state_nxt_s = S_DONE;
                else                 state_nxt_s = S_WAIT;
            end
            S_DONE: begin
                if (cancel)         state_nxt_s = S_IDLE;
                else if (xfer_s)    state_nxt_s = enter_s;
                else if (out_ready) state_nxt_s = S_IDLE;
                else                state_nxt_s = S_DONE;
            end
            default: state_nxt_s = S_IDLE;
        endcase
    end

    // State register.
    always_ff @(posedge clk or negedge resetn) begin
        if (!resetn) state_r <= S_IDLE;
        else         state_r <= state_nxt_s;
    end

    // Count of responses still owed by cancelled requests.
    always_ff @(posedge clk or negedge resetn) begin
        if (!resetn)                       drain_cnt_r <= DRAIN_ZERO;
        else if (drain_inc_s & ~drain_dec_s) drain_cnt_r <= drain_cnt_r + DRAIN_ONE;
        else if (drain_dec_s & ~drain_inc_s) drain_cnt_r <= drain_cnt_r - DRAIN_ONE;
        else                                 drain_cnt_r <= drain_cnt_r;
    end

    // Instruction latch on transfer; result overwritten by load data on its response.
    always_ff @(posedge clk or negedge resetn) begin
        if (!resetn) begin
            pc_r         <= 32'd0;
            addr_r       <= 32'd0;
            ld_r         <= 1'b0;
            st_r         <= 1'b0;
            size_r       <= 2'd0;
            sext_r       <= 1'b0;
            wstrb_r      <= 4'd0;
            sram_wdata_r <= 32'd0;
            rf_we_r      <= 1'b0;
            rf_waddr_r   <= {RF_AW{1'b0}};
            rf_wdata_r   <= 32'd0;
        end else if (xfer_s) begin
            pc_r         <= in_pc;
            addr_r       <= in_result;
            ld_r         <= in_mem_op[4];
            st_r         <= in_mem_op[3];
            size_r       <= in_mem_op[2:1];
            sext_r       <= in_mem_op[0];
            wstrb_r      <= store_strb(in_mem_op[2:1], in_result[1:0]);
            sram_wdata_r <= store_data(in_mem_op[2:1], in_wdata);
            rf_we_r      <= in_rf_we;
            rf_waddr_r   <= in_rf_waddr;
            rf_wdata_r   <= in_result;
        end else if (own_resp_s & ~cancel & ld_r) begin
            rf_wdata_r   <= load_data(size_r, sext_r, addr_r[1:0], data_sram_rdata);
        end else begin
            rf_wdata_r   <= rf_wdata_r;
        end
    end

`ifdef MEM_ALE_CHECK_EN
    logic        ale_r;
    logic [31:0] badv_r;

    // Misaligned-access exception latch.
    always_ff @(posedge clk or negedge resetn) begin
        if (!resetn) begin
            ale_r  <= 1'b0;
            badv_r <= 32'd0;
        end else if (xfer_s) begin
            ale_r  <= in_ale_s;
            badv_r <= in_ale_s ? in_result : 32'd0;
        end else begin
            ale_r  <= ale_r;
            badv_r <= badv_r;
        end
    end

    assign out_ale  = ale_r;
    assign out_badv = badv_r;
`else
    assign out_ale  = 1'b0;
    assign out_badv = 32'd0;
`endif

    assign out_valid       = (state_r == S_DONE);
    assign out_pc          = pc_r;
    assign out_rf_we       = rf_we_r & ~out_ale;
    assign out_rf_waddr    = rf_waddr_r;
    assign out_rf_wdata    = rf_wdata_r;
    assign fwd_busy        = ld_r & ((state_r == S_REQ) | (state_r == S_WAIT));
    assign data_sram_req   = (state_r == S_REQ);
    assign data_sram_wr    = st_r;
    assign data_sram_size  = size_r;
    assign data_sram_addr  = addr_r;
    assign data_sram_wstrb = wstrb_r;
    assign data_sram_wdata = sram_wdata_r;

endmodule

// File: tb/tb_mem_req_stage.sv
module tb_mem_req_stage;

    logic        clk = 1'b0;
    logic        resetn;
    logic        in_valid, in_allowin;
    logic [31:0] in_pc, in_result, in_wdata;
    logic [4:0]  in_mem_op;
    logic        in_rf_we;
    logic [4:0]  in_rf_waddr;
    logic        cancel;
    logic        out_valid, out_ready;
    logic [31:0] out_pc, out_rf_wdata, out_badv;
    logic        out_rf_we, out_ale, fwd_busy;
    logic [4:0]  out_rf_waddr;
    logic        data_sram_req, data_sram_wr;
    logic [1:0]  data_sram_size;
    logic [31:0] data_sram_addr, data_sram_wdata, data_sram_rdata;
    logic [3:0]  data_sram_wstrb;
    logic        data_sram_addr_ok, data_sram_data_ok;

    int checks = 0;
    int errors = 0;

    typedef struct {
        logic [31:0] pc;
        logic [31:0] wdata;
        logic        we;
        logic [4:0]  waddr;
        logic        ale;
        logic [31:0] badv;
    } exp_t;

    exp_t sb[$];

    mem_req_stage #(.RF_AW(5), .DRAIN_W(2)) dut (
        .clk(clk), .resetn(resetn),
        .in_valid(in_valid), .in_allowin(in_allowin),
        .in_pc(in_pc), .in_result(in_result), .in_mem_op(in_mem_op),
        .in_wdata(in_wdata), .in_rf_we(in_rf_we), .in_rf_waddr(in_rf_waddr),
        .cancel(cancel),
        .out_valid(out_valid), .out_ready(out_ready),
        .out_pc(out_pc), .out_rf_we(out_rf_we), .out_rf_waddr(out_rf_waddr),
        .out_rf_wdata(out_rf_wdata), .out_ale(out_ale), .out_badv(out_badv),
        .fwd_busy(fwd_busy),
        .data_sram_req(data_sram_req), .data_sram_wr(data_sram_wr),
        .data_sram_size(data_sram_size), .data_sram_addr(data_sram_addr),
        .data_sram_wstrb(data_sram_wstrb), .data_sram_wdata(data_sram_wdata),
        .data_sram_addr_ok(data_sram_addr_ok), .data_sram_data_ok(data_sram_data_ok),
        .data_sram_rdata(data_sram_rdata)
    );

    always #5 clk = ~clk;

    initial begin
        #200000;
        $display("FAIL watchdog observed timeout expected summary");
        $fatal(1, "watchdog");
    end

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed 0x%08h expected 0x%08h", tag, obs, exp);
        end
    endtask

    // Advance to just after the next falling edge.
    task automatic cyc();
        @(negedge clk);
        #1;
    endtask

    task automatic push_exp(input logic [31:0] pc, input logic [31:0] wd, input logic we,
                            input logic [4:0] wa, input logic ale, input logic [31:0] badv);
        exp_t e;
        e.pc = pc; e.wdata = wd; e.we = we; e.waddr = wa; e.ale = ale; e.badv = badv;
        sb.push_back(e);
    endtask

    // Offer one instruction for one cycle; returns in the cycle after the transfer.
    task automatic send(input logic [31:0] pc, input logic [31:0] res, input logic [4:0] op,
                        input logic [31:0] wd, input logic we, input logic [4:0] wa);
        in_valid = 1'b1; in_pc = pc; in_result = res; in_mem_op = op;
        in_wdata = wd; in_rf_we = we; in_rf_waddr = wa;
        #1;
        chk("send.allowin", 32'(in_allowin), 32'd1);
        cyc();
        in_valid = 1'b0;
    endtask

    task automatic check_out(input string tag);
        exp_t e;
        chk({tag, ".valid"}, 32'(out_valid), 32'd1);
        checks++;
        assert (sb.size() != 0) else begin
            errors++;
            $error("FAIL %s.sb observed empty expected entry", tag);
        end
        if (sb.size() != 0) begin
            e = sb.pop_front();
            chk({tag, ".pc"},    out_pc, e.pc);
            chk({tag, ".wdata"}, out_rf_wdata, e.wdata);
            chk({tag, ".we"},    32'(out_rf_we), 32'(e.we));
            chk({tag, ".waddr"}, 32'(out_rf_waddr), 32'(e.waddr));
            chk({tag, ".ale"},   32'(out_ale), 32'(e.ale));
            chk({tag, ".badv"},  out_badv, e.badv);
        end
    endtask

    initial begin
        resetn = 1'b0; in_valid = 1'b0; in_pc = 32'd0; in_result = 32'd0;
        in_mem_op = 5'd0; in_wdata = 32'd0; in_rf_we = 1'b0; in_rf_waddr = 5'd0;
        cancel = 1'b0; out_ready = 1'b1;
        data_sram_addr_ok = 1'b0; data_sram_data_ok = 1'b0; data_sram_rdata = 32'd0;
        #2;
        chk("rst.valid",   32'(out_valid), 32'd0);
        chk("rst.req",     32'(data_sram_req), 32'd0);
        chk("rst.rf_we",   32'(out_rf_we), 32'd0);
        chk("rst.ale",     32'(out_ale), 32'd0);
        chk("rst.fwd",     32'(fwd_busy), 32'd0);
        chk("rst.pc",      out_pc, 32'd0);
        chk("rst.wdata",   out_rf_wdata, 32'd0);
        chk("rst.allowin", 32'(in_allowin), 32'd1);
        cyc(); cyc();
        resetn = 1'b1;
        cyc();

        // Non-memory op: out_valid one cycle after transfer.
        send(32'h0000_0100, 32'hDEAD_BEEF, 5'b00000, 32'd0, 1'b1, 5'd3);
        push_exp(32'h0000_0100, 32'hDEAD_BEEF, 1'b1, 5'd3, 1'b0, 32'd0);
        check_out("alu");
        cyc();
        chk("alu.idle", 32'(out_valid), 32'd0);

        // ld.b sext at 0x1003.
        send(32'h0000_0200, 32'h0000_1003, 5'b10001, 32'd0, 1'b1, 5'd5);
        push_exp(32'h0000_0200, 32'hFFFF_FF80, 1'b1, 5'd5, 1'b0, 32'd0);
        chk("ldb.req",   32'(data_sram_req), 32'd1);
        chk("ldb.addr",  data_sram_addr, 32'h0000_1003);
        chk("ldb.size",  32'(data_sram_size), 32'd0);
        chk("ldb.wr",    32'(data_sram_wr), 32'd0);
        chk("ldb.fwd",   32'(fwd_busy), 32'd1);
        chk("ldb.early", 32'(out_valid), 32'd0);
        data_sram_addr_ok = 1'b1;
        cyc();
        data_sram_addr_ok = 1'b0;
        chk("ldb.req_off", 32'(data_sram_req), 32'd0);
        chk("ldb.wait",    32'(out_valid), 32'd0);
        data_sram_data_ok = 1'b1; data_sram_rdata = 32'h80FF_FF00;
        cyc();
        data_sram_data_ok = 1'b0;
        check_out("ldb");
        chk("ldb.fwd_done", 32'(fwd_busy), 32'd0);
        cyc();

        // st.h at 0x2002.
        send(32'h0000_0300, 32'h0000_2002, 5'b01010, 32'h1234_ABCD, 1'b0, 5'd0);
        push_exp(32'h0000_0300, 32'h0000_2002, 1'b0, 5'd0, 1'b0, 32'd0);
        chk("sth.wstrb", 32'(data_sram_wstrb), 32'hC);
        chk("sth.wdata", data_sram_wdata, 32'hABCD_ABCD);
        chk("sth.wr",    32'(data_sram_wr), 32'd1);
        chk("sth.size",  32'(data_sram_size), 32'd1);
        chk("sth.fwd",   32'(fwd_busy), 32'd0);
        data_sram_addr_ok = 1'b1;
        cyc();
        data_sram_addr_ok = 1'b0; data_sram_data_ok = 1'b1;
        cyc();
        data_sram_data_ok = 1'b0;
        check_out("sth");
        cyc();

        // ld.h zero-extend, late addr_ok, downstream backpressure.
        send(32'h0000_0400, 32'h0000_0010, 5'b10010, 32'd0, 1'b1, 5'd7);
        push_exp(32'h0000_0400, 32'h0000_8765, 1'b1, 5'd7, 1'b0, 32'd0);
        cyc();
        chk("ldh.req_hold", 32'(data_sram_req), 32'd1);
        data_sram_addr_ok = 1'b1;
        cyc();
        data_sram_addr_ok = 1'b0; data_sram_data_ok = 1'b1; data_sram_rdata = 32'h1234_8765;
        out_ready = 1'b0;
        cyc();
        data_sram_data_ok = 1'b0;
        chk("ldh.bp_allowin", 32'(in_allowin), 32'd0);
        cyc();
        chk("ldh.bp_hold", 32'(out_valid), 32'd1);
        out_ready = 1'b1;
        #1;
        check_out("ldh");
        cyc();

        // st.b then cancel in REQ without addr_ok: no discard owed.
        send(32'h0000_0500, 32'h0000_5001, 5'b01000, 32'h0000_00A5, 1'b0, 5'd0);
        chk("stb.wstrb", 32'(data_sram_wstrb), 32'h2);
        chk("stb.wdata", data_sram_wdata, 32'hA5A5_A5A5);
        cancel = 1'b1;
        cyc();
        cancel = 1'b0;
        chk("stb.cancel_req", 32'(data_sram_req), 32'd0);
        chk("stb.cancel_val", 32'(out_valid), 32'd0);
        // Offer in a cancel cycle is ignored.
        in_valid = 1'b1; in_mem_op = 5'b10100; in_result = 32'h0000_5008; cancel = 1'b1;
        cyc();
        in_valid = 1'b0; cancel = 1'b0;
        chk("cxl.ign_req", 32'(data_sram_req), 32'd0);
        chk("cxl.ign_val", 32'(out_valid), 32'd0);
        send(32'h0000_0510, 32'h0000_5004, 5'b10100, 32'd0, 1'b1, 5'd8);
        push_exp(32'h0000_0510, 32'h0000_0077, 1'b1, 5'd8, 1'b0, 32'd0);
        data_sram_addr_ok = 1'b1;
        cyc();
        data_sram_addr_ok = 1'b0; data_sram_data_ok = 1'b1; data_sram_rdata = 32'h0000_0077;
        cyc();
        data_sram_data_ok = 1'b0;
        check_out("nodrain");
        cyc();

        // Cancel in WAIT, then next load's first data_ok is discarded.
        send(32'h0000_0600, 32'h0000_0040, 5'b10100, 32'd0, 1'b1, 5'd9);
        data_sram_addr_ok = 1'b1;
        cyc();
        data_sram_addr_ok = 1'b0; cancel = 1'b1;
        cyc();
        cancel = 1'b0;
        chk("disc.idle", 32'(out_valid), 32'd0);
        send(32'h0000_0610, 32'h0000_0044, 5'b10100, 32'd0, 1'b1, 5'd10);
        push_exp(32'h0000_0610, 32'h0000_0022, 1'b1, 5'd10, 1'b0, 32'd0);
        chk("disc.addr", data_sram_addr, 32'h0000_0044);
        data_sram_addr_ok = 1'b1;
        cyc();
        data_sram_addr_ok = 1'b0; data_sram_data_ok = 1'b1; data_sram_rdata = 32'h0000_0011;
        cyc();
        chk("disc.first", 32'(out_valid), 32'd0);
        chk("disc.fwd",   32'(fwd_busy), 32'd1);
        data_sram_rdata = 32'h0000_0022;
        cyc();
        data_sram_data_ok = 1'b0;
        check_out("disc");
        cyc();

        // Three cancels in WAIT saturate the drain counter.
        for (int k = 0; k < 3; k++) begin
            send(32'h0000_0700 + 32'(k), 32'h0000_0080 + 32'(4 * k), 5'b10100, 32'd0, 1'b1, 5'd1);
            data_sram_addr_ok = 1'b1;
            cyc();
            data_sram_addr_ok = 1'b0; cancel = 1'b1;
            cyc();
            cancel = 1'b0;
            #1;
            chk("sat.allowin", 32'(in_allowin), (k < 2) ? 32'd1 : 32'd0);
        end
        in_valid = 1'b1; in_mem_op = 5'b10100; in_result = 32'h0000_0090;
        cyc();
        in_valid = 1'b0;
        chk("sat.noreq",   32'(data_sram_req), 32'd0);
        chk("sat.allowin2", 32'(in_allowin), 32'd0);
        data_sram_data_ok = 1'b1;
        cyc();
        data_sram_data_ok = 1'b0;
        chk("sat.release", 32'(in_allowin), 32'd1);
        data_sram_data_ok = 1'b1;
        cyc(); cyc();
        data_sram_data_ok = 1'b0;

`ifdef MEM_ALE_CHECK_EN
        // Misaligned word raises ALE with no request.
        send(32'h0000_0800, 32'h0000_3002, 5'b10100, 32'd0, 1'b1, 5'd4);
        push_exp(32'h0000_0800, 32'h0000_3002, 1'b0, 5'd4, 1'b1, 32'h0000_3002);
        chk("ale.noreq", 32'(data_sram_req), 32'd0);
        check_out("ale");
        cyc();
`else
        // Misaligned word issues normally when checking is disabled.
        send(32'h0000_0800, 32'h0000_3002, 5'b10100, 32'd0, 1'b1, 5'd4);
        push_exp(32'h0000_0800, 32'hCAFE_F00D, 1'b1, 5'd4, 1'b0, 32'd0);
        chk("mis.req",  32'(data_sram_req), 32'd1);
        chk("mis.addr", data_sram_addr, 32'h0000_3002);
        data_sram_addr_ok = 1'b1;
        cyc();
        data_sram_addr_ok = 1'b0; data_sram_data_ok = 1'b1; data_sram_rdata = 32'hCAFE_F00D;
        cyc();
        data_sram_data_ok = 1'b0;
        check_out("mis");
        cyc();
`endif

        // Asynchronous reset in WAIT.
        send(32'h0000_0900, 32'h0000_0090, 5'b10100, 32'd0, 1'b1, 5'd6);
        data_sram_addr_ok = 1'b1;
        cyc();
        data_sram_addr_ok = 1'b0;
        chk("arst.fwd_pre", 32'(fwd_busy), 32'd1);
        chk("arst.pc_pre",  out_pc, 32'h0000_0900);
        #2;
        resetn = 1'b0;
        #1;
        chk("arst.valid",   32'(out_valid), 32'd0);
        chk("arst.fwd",     32'(fwd_busy), 32'd0);
        chk("arst.req",     32'(data_sram_req), 32'd0);
        chk("arst.pc",      out_pc, 32'd0);
        chk("arst.rf_we",   32'(out_rf_we), 32'd0);
        chk("arst.allowin", 32'(in_allowin), 32'd1);
        cyc();
        resetn = 1'b1;
        cyc();

        checks++;
        assert (sb.size() == 0) else begin
            errors++;
            $error("FAIL sb.leftover observed %0d expected 0", sb.size());
        end

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
